// File: rtl/iir_out_capture.sv
// iir_out_capture: receiving end of the IIR output stream. Captures a
// programmed number of VIN-strobed samples into a show-ahead FIFO and
// exposes them on a valid/ready readout port, with run status flags.
module iir_out_capture #(
  parameter int NB    = 13,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN,
  input  logic [NB-1:0] DIN,
  input  logic          ARM,
  input  logic [CW-1:0] NSAMP,
  input  logic          RD_READY,
  output logic          RD_VALID,
  output logic [NB-1:0] RD_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF,
  output logic [CW-1:0] COUNT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] nsamp_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [NB-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic rd_fire;
  logic strobe;
  logic wr_en;
  logic drop;
  logic last;

  // Occupancy decode and per-cycle event qualification; ARM pre-empts VIN.
  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  assign rd_fire = !empty && RD_READY;
  assign strobe  = (state == S_CAPT) && VIN && !ARM;
  assign wr_en   = strobe && (!full || rd_fire);
  assign drop    = strobe && full && !rd_fire;
  assign last    = strobe && (count_q == nsamp_q - CW'(1));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: ARM (re)starts a run from any state, a zero-length
  // run finishes immediately, and the final strobe of a run ends it.
  always_comb begin
    state_next = state;
    if (ARM) begin
      state_next = (NSAMP == '0) ? S_DONE : S_CAPT;
    end else if (last) begin
      state_next = S_DONE;
    end
  end

  // Run bookkeeping: latched length, saturating sample count, sticky overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nsamp_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (ARM) begin
      nsamp_q <= NSAMP;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (strobe) begin
      if (count_q != '1) count_q <= count_q + CW'(1);
      if (drop)          ovf_q   <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; ARM discards everything still stored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (ARM) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_fire})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sample storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= DIN;
  end

  assign RD_VALID = !empty;
  assign RD_DATA  = empty ? '0 : mem[rd_ptr];
  assign BUSY     = (state == S_CAPT);
  assign DONE     = (state == S_DONE);
  assign OVF      = ovf_q;
  assign COUNT    = count_q;

endmodule

// File: tb/tb_iir_out_capture.sv
// tb_iir_out_capture: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_iir_out_capture;

  localparam int NB    = 13;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          VIN = 1'b0;
  logic [NB-1:0] DIN = '0;
  logic          ARM = 1'b0;
  logic [CW-1:0] NSAMP = '0;
  logic          RD_READY = 1'b0;
  logic          RD_VALID;
  logic [NB-1:0] RD_DATA;
  logic          BUSY;
  logic          DONE;
  logic          OVF;
  logic [CW-1:0] COUNT;

  int total_checks = 0;
  int bad_checks   = 0;

  // Behavioural model: stored samples as a queue plus run status.
  logic [NB-1:0] m_q[$];
  int            m_count  = 0;
  int            m_target = 0;
  bit            m_busy   = 0;
  bit            m_done   = 0;
  bit            m_ovf    = 0;

  iir_out_capture #(.NB(NB), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .VIN      (VIN),
    .DIN      (DIN),
    .ARM      (ARM),
    .NSAMP    (NSAMP),
    .RD_READY (RD_READY),
    .RD_VALID (RD_VALID),
    .RD_DATA  (RD_DATA),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVF      (OVF),
    .COUNT    (COUNT)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_count = 0;
    m_target = 0;
    m_busy = 0;
    m_done = 0;
    m_ovf = 0;
  endtask

  // One clock edge of the model, using the inputs that were present at the edge.
  task automatic modelStep(input bit arm, input int nsamp, input bit vin,
                           input logic [NB-1:0] din, input bit rdy);
    bit hs;
    hs = (m_q.size() > 0) && rdy;
    if (arm) begin
      m_q.delete();
      m_count = 0;
      m_ovf = 0;
      m_target = nsamp;
      m_busy = (nsamp != 0);
      m_done = (nsamp == 0);
    end else begin
      if (hs) void'(m_q.pop_front());
      if (m_busy && vin) begin
        if (m_count < 65535) m_count++;
        if (m_q.size() < DEPTH) m_q.push_back(din);
        else m_ovf = 1;
        if (m_count == m_target) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("rd_valid", RD_VALID, (m_q.size() > 0) ? 1 : 0);
    checkOutput("rd_data",  RD_DATA,  (m_q.size() > 0) ? m_q[0] : 0);
    checkOutput("busy",     BUSY,     m_busy);
    checkOutput("done",     DONE,     m_done);
    checkOutput("ovf",      OVF,      m_ovf);
    checkOutput("count",    COUNT,    m_count);
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the rising edge.
  task automatic applyStimulus(input bit arm, input int nsamp, input bit vin,
                               input logic [NB-1:0] din, input bit rdy);
    @(negedge CLK);
    ARM = arm;
    NSAMP = nsamp[CW-1:0];
    VIN = vin;
    DIN = din;
    RD_READY = rdy;
    @(posedge CLK);
    modelStep(arm, nsamp, vin, din, rdy);
    #1;
    compareAll();
  endtask

  initial begin
    logic [NB-1:0] basic_vals [5];
    basic_vals[0] = 13'h0001;
    basic_vals[1] = 13'h1FFF;
    basic_vals[2] = 13'h0FFF;
    basic_vals[3] = 13'h1000;
    basic_vals[4] = 13'h0000;

    // Reset state.
    #12;
    checkOutput("reset_busy",  BUSY, 0);
    checkOutput("reset_count", COUNT, 0);
    @(negedge CLK);
    RST = 1'b0;
    modelReset();
    applyStimulus(0, 0, 1, 13'h0AA, 0);

    // Reset mid-run.
    applyStimulus(1, 8, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, NB'(i + 7), 0);
    #2;
    RST = 1'b1;
    ARM = 1'b0;
    RD_READY = 1'b0;
    VIN = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_async_valid", RD_VALID, 0);
    checkOutput("rst_async_count", COUNT, 0);
    compareAll();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, NB'(i + 3), 0);

    // Basic capture with signed boundary values, then read out.
    applyStimulus(1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, basic_vals[i], 0);
    checkOutput("basic_count", COUNT, 5);
    checkOutput("basic_done",  DONE, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("basic_drained", RD_VALID, 0);

    // Overflow: 20 samples into a 16-entry FIFO.
    applyStimulus(1, 20, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, NB'(i), 0);
    checkOutput("ovf_flag",  OVF, 1);
    checkOutput("ovf_count", COUNT, 20);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 1);

    // Full FIFO with concurrent reads across pointer wrap.
    applyStimulus(1, 40, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, NB'(100 + i), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, NB'(200 + i), 1);
    checkOutput("full_rd_noovf", OVF, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 1);

    // Empty boundary: write and read-ready together on an empty FIFO.
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(0, 0, 1, 13'h0123, 1);
    checkOutput("empty_wr_valid", RD_VALID, 1);
    checkOutput("empty_wr_data",  RD_DATA, 13'h0123);
    applyStimulus(0, 0, 1, 13'h0456, 1);
    applyStimulus(0, 0, 1, 13'h0789, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

    // Re-arm in DONE with unread entries and a simultaneous strobe.
    applyStimulus(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, NB'(50 + i), 0);
    applyStimulus(1, 2, 1, 13'h1555, 0);
    checkOutput("rearm_count", COUNT, 0);
    checkOutput("rearm_empty", RD_VALID, 0);
    applyStimulus(0, 0, 1, 13'h0011, 0);
    applyStimulus(0, 0, 1, 13'h0022, 0);
    checkOutput("rearm_done", DONE, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

    // Zero-length run goes straight to DONE.
    applyStimulus(1, 0, 1, 13'h0077, 0);
    checkOutput("nsamp0_done", DONE, 1);
    applyStimulus(0, 0, 1, 13'h0078, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit arm;
      arm = ($urandom_range(0, 39) == 0);
      applyStimulus(arm, $urandom_range(0, 24), $urandom_range(0, 1) == 1,
                    NB'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/iir_out_capture.md
Name: iir_out_capture

Overview:
- Synthesizable receiving end of the filter's output stream (DOUT/VOUT), the hardware counterpart of the bench sink.
- Captures a programmed number of filter output samples, strobed by VIN, into an internal FIFO.
- Exposes the samples on a valid/ready readout port.
- Reports completion, overflow and a running sample count, so on-chip/FPGA runs of the IIR can be checked without a simulator file dump.

Parameters:
- NB, 13, sample width in bits; matches the filter datapath.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- CW, 16, width of the sample counter and of NSAMP.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- VIN  in  1  sample strobe from filter VOUT; one sample per high cycle.
- DIN  in  NB  sample from filter DOUT, two's complement; valid when VIN=1.
- ARM  in  1  single-cycle pulse: clear state and start a capture run.
- NSAMP  in  CW  samples to capture per run; sampled on ARM.
- RD_READY  in  1  reader accepts RD_DATA this cycle.
- RD_VALID  out  1  FIFO non-empty.
- RD_DATA  out  NB  oldest stored sample (show-ahead).
- BUSY  out  1  capture run in progress.
- DONE  out  1  run finished; sticky until next ARM or reset.
- OVF  out  1  sticky: at least one sample dropped because the FIFO was full.
- COUNT  out  CW  samples seen by VIN in the current run, accepted or dropped.

Behaviour:
- Reset (asynchronous, RST=1):
  - Forces state IDLE and clears both FIFO pointers and the occupancy count.
  - Outputs: RD_VALID=0, BUSY=0, DONE=0, OVF=0, COUNT=0.
  - RD_DATA is don't-care while RD_VALID=0; the implementation drives 0.
  - Reset mid-run discards all stored samples.
- States:
  - IDLE: VIN ignored.
  - CAPT: BUSY=1.
  - DONE: DONE=1, VIN ignored.
- Transitions:
  - IDLE or DONE → CAPT on ARM=1. On the same edge: latch NSAMP, COUNT←0, OVF←0, DONE←0, FIFO pointers←0. Unread data is discarded.
  - ARM while in CAPT restarts the run identically.
  - CAPT → DONE on the edge where VIN=1 and COUNT=latched NSAMP−1. That last sample is written if space allows.
  - ARM with NSAMP=0 goes IDLE→DONE directly with COUNT=0.
- Capture in CAPT with VIN=1:
  - COUNT increments by 1, saturating at 2^CW−1.
  - If not full, DIN is written at the write pointer and the write pointer increments, wrapping modulo DEPTH.
  - If full and no read handshake this cycle, the sample is dropped and OVF←1.
  - If full and a read handshake occurs in the same cycle, the write is accepted. No drop, occupancy unchanged.
- Readout:
  - Handshake = RD_VALID & RD_READY. On handshake the read pointer increments (mod DEPTH) on the clock edge.
  - RD_DATA always shows mem[read pointer] with no read latency.
  - RD_VALID depends only on occupancy (not combinationally on RD_READY). It stays asserted in DONE until the FIFO drains.
  - Reads are allowed in every state.
  - Simultaneous write and read on an empty FIFO: the write is accepted, no read occurs, and RD_VALID rises the next cycle.
- Occupancy: counter 0..DEPTH; full = DEPTH, empty = 0. Fill and drain wrap-around must be exact.
- Latency: a sample strobed at edge k is visible on RD_DATA/RD_VALID after edge k when the FIFO was empty.
- ARM and VIN in the same cycle: ARM wins and the sample is not captured.

Test Plan:
- Reset mid-run: ARM with NSAMP=8, 3 samples in, assert RST asynchronously between edges → all outputs 0 immediately, RD_VALID=0; subsequent VIN ignored until ARM.
- Basic capture: ARM NSAMP=5, VIN on 5 consecutive cycles with DIN=1,−1,4095,−4096,0, RD_READY=0 → COUNT=5, DONE=1 after the 5th edge, BUSY=0. Reading then returns 0x0001,0x1FFF,0x0FFF,0x1000,0x0000 in order; RD_VALID drops after the 5th handshake.
- Overflow: DEPTH=16, ARM NSAMP=20, 20 strobes with DIN=0..19, RD_READY=0 → OVF=1, COUNT=20, DONE=1. Readout yields 0..15 only.
- Full with concurrent read: fill to 16 entries, then VIN=1 with RD_READY=1 for 4 cycles → no OVF, occupancy stays 16, the read order is continuous across pointer wrap.
- Empty boundary: VIN=1 and RD_READY=1 on an empty FIFO → no handshake that cycle, RD_VALID=1 next cycle with that sample.
- Re-arm: in DONE with 3 unread entries, pulse ARM with NSAMP=2 and VIN=1 in the same cycle → FIFO emptied, COUNT=0, the simultaneous sample is not stored. The next 2 strobes complete the run.
